// File: rtl/ov7670_frame_sched_if.sv
// Control/status bundle between the OV7670 frame sequencer and its neighbours.
// master = sequencer side (drives strobes/status), slave = surrounding capture path.
interface ov7670_frame_sched_if;
    logic       CAP_REQ;
    logic       CONTINUOUS;
    logic       INIT_DONE;
    logic       OV_VSYNC;
    logic       RD_DONE;
    logic       INIT_EN;
    logic       OV_WRRST;
    logic       OV_WEN;
    logic       READ_EN;
    logic       BUSY;
    logic       ERR_TIMEOUT;
    logic [7:0] FRAME_CNT;

    modport master (
        input  CAP_REQ, CONTINUOUS, INIT_DONE, OV_VSYNC, RD_DONE,
        output INIT_EN, OV_WRRST, OV_WEN, READ_EN, BUSY, ERR_TIMEOUT, FRAME_CNT
    );

    modport slave (
        output CAP_REQ, CONTINUOUS, INIT_DONE, OV_VSYNC, RD_DONE,
        input  INIT_EN, OV_WRRST, OV_WEN, READ_EN, BUSY, ERR_TIMEOUT, FRAME_CNT
    );
endinterface

// File: rtl/ov7670_frame_sched.sv
// OV7670/AL422B frame sequencer: init, AEC skip, one-frame capture, readout handoff, watchdog.
// All outputs registered (1 cycle after the deciding event); VSYNC edges act 3 cycles after the pin rises.
module ov7670_frame_sched #(
    parameter int WRRST_CYCLES   = 4,
    parameter int SKIP_FRAMES    = 2,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TO_W           = 26
) (
    input  logic                 SYS_CLK,
    input  logic                 RST,
    ov7670_frame_sched_if.master bus
);
    localparam int WR_W = (WRRST_CYCLES > 1) ? $clog2(WRRST_CYCLES) : 1;
    localparam int SK_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WR_W-1:0] WR_LAST = WR_W'(WRRST_CYCLES - 1);
    localparam logic [SK_W-1:0] SK_LOAD = SK_W'(SKIP_FRAMES);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_SKIP, S_WAIT_VS, S_WRRST, S_WRITE, S_READ
    } state_t;

    state_t          state, state_nx;
    logic            vs_s1, vs_s2, vs_h, vs_rise;
    logic            init_first;
    logic            counting;
    logic [TO_W-1:0] wd, wd_nx;
    logic [WR_W-1:0] wr_cnt, wr_cnt_nx;
    logic [SK_W-1:0] skip_cnt, skip_cnt_nx;
    logic            init_en;
    logic            wrrst_n, wrrst_n_nx;
    logic            wen, wen_nx;
    logic            rden, rden_nx;
    logic            busy, busy_nx;
    logic            err, err_nx;
    logic [7:0]      frame_cnt, frame_cnt_nx;

    assign vs_rise = vs_s2 & ~vs_h;

    always_comb begin
        state_nx     = state;
        wr_cnt_nx    = wr_cnt;
        skip_cnt_nx  = skip_cnt;
        wrrst_n_nx   = 1'b1;
        wen_nx       = 1'b0;
        rden_nx      = 1'b0;
        err_nx       = err;
        frame_cnt_nx = frame_cnt;

        case (state)
            S_INIT: begin
                if (bus.INIT_DONE) state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (bus.CAP_REQ) begin
                    err_nx      = 1'b0;
                    skip_cnt_nx = SK_LOAD;
                    state_nx    = S_SKIP;
                end
            end
            S_SKIP: begin
                if (skip_cnt == '0) state_nx = S_WAIT_VS;
                else if (vs_rise)   skip_cnt_nx = skip_cnt - 1'b1;
            end
            S_WAIT_VS: begin
                if (vs_rise) begin
                    state_nx   = S_WRRST;
                    wr_cnt_nx  = '0;
                    wrrst_n_nx = 1'b0;
                end
            end
            S_WRRST: begin
                if (wr_cnt == WR_LAST) begin
                    state_nx = S_WRITE;
                end else begin
                    wr_cnt_nx  = wr_cnt + 1'b1;
                    wrrst_n_nx = 1'b0;
                end
            end
            S_WRITE: begin
                // WEN rises one cycle after WRRST is released; READ_EN takes over at the closing edge
                if (vs_rise) begin
                    state_nx = S_READ;
                    rden_nx  = 1'b1;
                end else begin
                    wen_nx = 1'b1;
                end
            end
            S_READ: begin
                if (bus.RD_DONE) begin
                    frame_cnt_nx = frame_cnt + 1'b1;
                    state_nx     = bus.CONTINUOUS ? S_WAIT_VS : S_IDLE;
                end else begin
                    rden_nx = 1'b1;
                end
            end
            default: state_nx = S_INIT;
        endcase

        counting = (state != S_IDLE) && (state != S_WRRST);
        if (counting && wd == WD_LAST) begin
            state_nx     = S_IDLE;
            err_nx       = 1'b1;
            wrrst_n_nx   = 1'b1;
            wen_nx       = 1'b0;
            rden_nx      = 1'b0;
            frame_cnt_nx = frame_cnt;
        end

        wd_nx   = (!counting || state_nx != state) ? '0 : wd + 1'b1;
        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state      <= S_INIT;
            vs_s1      <= 1'b0;
            vs_s2      <= 1'b0;
            vs_h       <= 1'b0;
            init_first <= 1'b1;
            init_en    <= 1'b0;
            wd         <= '0;
            wr_cnt     <= '0;
            skip_cnt   <= '0;
            wrrst_n    <= 1'b1;
            wen        <= 1'b0;
            rden       <= 1'b0;
            busy       <= 1'b1;
            err        <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nx;
            vs_s1      <= bus.OV_VSYNC;
            vs_s2      <= vs_s1;
            vs_h       <= vs_s2;
            init_first <= 1'b0;
            init_en    <= init_first;
            wd         <= wd_nx;
            wr_cnt     <= wr_cnt_nx;
            skip_cnt   <= skip_cnt_nx;
            wrrst_n    <= wrrst_n_nx;
            wen        <= wen_nx;
            rden       <= rden_nx;
            busy       <= busy_nx;
            err        <= err_nx;
            frame_cnt  <= frame_cnt_nx;
        end
    end

    assign bus.INIT_EN     = init_en;
    assign bus.OV_WRRST    = wrrst_n;
    assign bus.OV_WEN      = wen;
    assign bus.READ_EN     = rden;
    assign bus.BUSY        = busy;
    assign bus.ERR_TIMEOUT = err;
    assign bus.FRAME_CNT   = frame_cnt;
endmodule

// File: tb/tb_ov7670_frame_sched.sv
// Directed-random bench: VSYNC/RD_DONE timing randomised, expected waveform windows derived from event times.
module tb_ov7670_frame_sched;
    localparam int MAXC = 65536;

    logic clk = 1'b0;
    logic rst;
    ov7670_frame_sched_if bus();

    ov7670_frame_sched #(
        .WRRST_CYCLES(4), .SKIP_FRAMES(2), .TIMEOUT_CYCLES(100), .TO_W(7)
    ) dut (
        .SYS_CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int vecs = 0;
    int errs = 0;
    int vs_hold = 0;
    int ovl = 0;
    int exp_cnt = 0;

    bit         lg_wrrst [0:MAXC-1];
    bit         lg_wen   [0:MAXC-1];
    bit         lg_rden  [0:MAXC-1];
    bit         lg_busy  [0:MAXC-1];
    bit         lg_err   [0:MAXC-1];
    bit         lg_init  [0:MAXC-1];
    logic [7:0] lg_cnt   [0:MAXC-1];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (vs_hold > 0) begin
            vs_hold--;
            if (vs_hold == 0) bus.OV_VSYNC = 1'b0;
        end
        if (cyc < MAXC) begin
            lg_wrrst[cyc] = bus.OV_WRRST;
            lg_wen[cyc]   = bus.OV_WEN;
            lg_rden[cyc]  = bus.READ_EN;
            lg_busy[cyc]  = bus.BUSY;
            lg_err[cyc]   = bus.ERR_TIMEOUT;
            lg_init[cyc]  = bus.INIT_EN;
            lg_cnt[cyc]   = bus.FRAME_CNT;
        end
        if (bus.OV_WEN && bus.READ_EN) ovl++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic vs_pulse(output int at);
        bus.OV_VSYNC = 1'b1;
        vs_hold = 3;
        at = cyc;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int cnt_hi(input int sel, input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) begin
            case (sel)
                0:       n += int'(lg_wrrst[i]);
                1:       n += int'(lg_wen[i]);
                2:       n += int'(lg_rden[i]);
                default: n += int'(lg_init[i]);
            endcase
        end
        return n;
    endfunction

    // Pin rise at cycle p is acted on 3 cycles later; WRRST low 4 cycles, WEN from the cycle after release.
    task automatic check_frame(input int p3, input int p4, input int r);
        chk("wrrst_before",   lg_wrrst[p3+2], 1);
        chk("wrrst_low_len",  4 - cnt_hi(0, p3+3, p3+6), 4);
        chk("wrrst_after",    lg_wrrst[p3+7], 1);
        chk("wen_before",     lg_wen[p3+7], 0);
        chk("wen_window",     cnt_hi(1, p3+8, p4+2), p4 - p3 - 5);
        chk("wen_after",      lg_wen[p4+3], 0);
        chk("rden_before",    lg_rden[p4+2], 0);
        chk("rden_window",    cnt_hi(2, p4+3, r), r - p4 - 2);
        chk("rden_after",     lg_rden[r+1], 0);
        chk("frame_cnt",      int'(lg_cnt[r+1]), exp_cnt);
    endtask

    task automatic frame(input bit inject, input bit last, input int glo, input int ghi, output int p3);
        int p4, r, g, d;
        vs_pulse(p3);
        g = int'($urandom_range(ghi, glo));
        if (inject) begin
            ticks(12);
            bus.CAP_REQ = 1'b1;
            bus.RD_DONE = 1'b1;
            tick();
            bus.CAP_REQ = 1'b0;
            bus.RD_DONE = 1'b0;
            ticks(g - 13);
        end else begin
            ticks(g);
        end
        vs_pulse(p4);
        d = 3 + int'($urandom_range(5, 0));
        ticks(d);
        if (last) bus.CONTINUOUS = 1'b0;
        r = cyc;
        bus.RD_DONE = 1'b1;
        tick();
        bus.RD_DONE = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        check_frame(p3, p4, r);
    endtask

    task automatic capture(input bit inject, input bit cont, input int nfr, input int glo, input int ghi);
        int c0, pd, p3;
        bus.CONTINUOUS = cont;
        ticks(int'($urandom_range(5, 2)));
        c0 = cyc;
        bus.CAP_REQ = 1'b1;
        tick();
        bus.CAP_REQ = 1'b0;
        chk("err_clear_on_cap", int'(lg_err[c0+1]), 0);
        chk("busy_on_cap", int'(lg_busy[c0+1]), 1);
        for (int k = 0; k < 2; k++) begin
            ticks(int'($urandom_range(30, 12)));
            vs_pulse(pd);
        end
        ticks(int'($urandom_range(30, 12)));
        for (int f = 0; f < nfr; f++) begin
            if (f > 0) ticks(int'($urandom_range(15, 1)));
            frame(inject, f == nfr - 1, glo, ghi, p3);
            if (f == 0) chk("no_wrrst_in_skip", cnt_hi(0, c0, p3+2), p3 + 3 - c0);
        end
        ticks(3);
        chk("idle_after_frame", int'(bus.BUSY), 0);
    endtask

    initial begin
        int t0, c0, pd, p3, p4;
        rst = 1'b1;
        bus.CAP_REQ = 1'b0;
        bus.CONTINUOUS = 1'b0;
        bus.INIT_DONE = 1'b0;
        bus.OV_VSYNC = 1'b0;
        bus.RD_DONE = 1'b0;
        ticks(3);
        chk("rst_init_en",   int'(bus.INIT_EN), 0);
        chk("rst_wrrst",     int'(bus.OV_WRRST), 1);
        chk("rst_wen",       int'(bus.OV_WEN), 0);
        chk("rst_read_en",   int'(bus.READ_EN), 0);
        chk("rst_busy",      int'(bus.BUSY), 1);
        chk("rst_err",       int'(bus.ERR_TIMEOUT), 0);
        chk("rst_frame_cnt", int'(bus.FRAME_CNT), 0);

        rst = 1'b0;
        t0 = cyc;
        ticks(20);
        bus.INIT_DONE = 1'b1;
        tick();
        bus.INIT_DONE = 1'b0;
        tick();
        chk("init_en_cycle1", int'(lg_init[t0+1]), 1);
        chk("init_en_once",   cnt_hi(3, t0+1, t0+22), 1);
        chk("busy_in_init",   int'(lg_busy[t0+20]), 1);
        chk("busy_idle_c22",  int'(lg_busy[t0+22]), 0);
        chk("idle_wen",       int'(bus.OV_WEN) + int'(bus.READ_EN), 0);
        chk("idle_wrrst",     int'(bus.OV_WRRST), 1);

        capture(1'b0, 1'b0, 1, 20, 35);
        capture(1'b1, 1'b0, 1, 20, 35);
        capture(1'b0, 1'b1, 3, 20, 35);
        capture(1'b0, 1'b1, 256 - exp_cnt, 12, 20);
        chk("frame_cnt_wrap", int'(bus.FRAME_CNT), 0);

        // VSYNC held low: SKIP must time out 100 cycles after entry
        ticks(3);
        c0 = cyc;
        bus.CAP_REQ = 1'b1;
        tick();
        bus.CAP_REQ = 1'b0;
        ticks(100);
        chk("to_err_early",  int'(lg_err[c0+100]), 0);
        chk("to_err_set",    int'(lg_err[c0+101]), 1);
        chk("to_busy_clear", int'(lg_busy[c0+101]), 0);
        chk("to_no_strobes", cnt_hi(1, c0, c0+101) + cnt_hi(2, c0, c0+101), 0);
        ticks(5);
        chk("to_err_sticky", int'(bus.ERR_TIMEOUT), 1);
        capture(1'b0, 1'b0, 1, 20, 35);

        bus.CONTINUOUS = 1'b0;
        ticks(3);
        bus.CAP_REQ = 1'b1;
        tick();
        bus.CAP_REQ = 1'b0;
        ticks(15); vs_pulse(pd);
        ticks(15); vs_pulse(pd);
        ticks(15); vs_pulse(p3);
        ticks(25); vs_pulse(p4);
        ticks(5);
        chk("read_before_rst", int'(bus.READ_EN), 1);
        rst = 1'b1;
        tick();
        chk("rst_mid_read_en", int'(bus.READ_EN), 0);
        chk("rst_mid_cnt",     int'(bus.FRAME_CNT), 0);
        chk("rst_mid_busy",    int'(bus.BUSY), 1);
        chk("rst_mid_init_en", int'(bus.INIT_EN), 0);
        rst = 1'b0;
        exp_cnt = 0;
        tick();
        chk("reinit_pulse",    int'(bus.INIT_EN), 1);
        tick();
        chk("reinit_pulse_end", int'(bus.INIT_EN), 0);
        bus.INIT_DONE = 1'b1;
        tick();
        bus.INIT_DONE = 1'b0;
        tick();
        chk("reinit_idle", int'(bus.BUSY), 0);
        capture(1'b0, 1'b0, 1, 20, 35);

        chk("wen_rden_overlap", ovl, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
